// File: rtl/vpu_pkg.sv
// VPU SRAM subsystem shared parameters and types.
// Imported by the bank-side read responder and its arbiter.
package vpu_pkg;

  localparam int SRAM_R_PORT_CNT     = 3;
  localparam int SRAM_BANK_CNT_LG2   = 2;
  localparam int SRAM_BANK_DEPTH_LG2 = 8;
  localparam int SRAM_DATA_WIDTH     = 32;
  localparam int SRAM_RD_LAT         = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BURST,
    DRAIN
  } rd_rsp_state_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vpu_rr_arbiter.sv
// Round-robin picker: first request at or after the pointer,
// wrapping modulo N, as a one-hot grant plus its index.
module vpu_rr_arbiter
  import vpu_pkg::*;
#(
  parameter int N = SRAM_R_PORT_CNT,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  int   j;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr_i) + i) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/vpu_sram_rd_responder.sv
// Bank-side read responder: round-robin bank ownership, SRAM
// read drive, and fixed-latency data return to the owning port.
module vpu_sram_rd_responder
  import vpu_pkg::*;
#(
  parameter int R_PORT_CNT   = SRAM_R_PORT_CNT,
  parameter int BANK_ID      = 0,
  parameter int BANK_CNT_LG2 = SRAM_BANK_CNT_LG2,
  parameter int DEPTH_LG2    = SRAM_BANK_DEPTH_LG2,
  parameter int DATA_WIDTH   = SRAM_DATA_WIDTH,
  parameter int RD_LAT       = SRAM_RD_LAT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [R_PORT_CNT-1:0]              rreq_i,
  input  logic [R_PORT_CNT*BANK_CNT_LG2-1:0] rid_i,
  input  logic [R_PORT_CNT*DEPTH_LG2-1:0]    raddr_i,
  input  logic [R_PORT_CNT-1:0]              reb_i,
  input  logic [R_PORT_CNT-1:0]              rlast_i,
  output logic [R_PORT_CNT-1:0]              rack_o,
  output logic [R_PORT_CNT*DATA_WIDTH-1:0]   rdata_o,
  output logic [R_PORT_CNT-1:0]              rvalid_o,
  output logic                               sram_csb_o,
  output logic [DEPTH_LG2-1:0]               sram_addr_o,
  input  logic [DATA_WIDTH-1:0]              sram_rdata_i
);

  localparam int OW = idx_w(R_PORT_CNT);
  localparam logic [BANK_CNT_LG2-1:0] BANK_ID_L =
    BANK_CNT_LG2'(BANK_ID);

  rd_rsp_state_t state_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] ptr_q;
  logic [R_PORT_CNT-1:0] rack_q;

  logic [R_PORT_CNT-1:0] cand;
  logic [R_PORT_CNT-1:0] gnt;
  logic [OW-1:0]         gnt_idx;
  logic                  gnt_vld;
  logic [DEPTH_LG2-1:0]  addr_a [R_PORT_CNT];

  logic beat;
  logic last_beat;
  logic pipe_empty;

  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [OW-1:0]     pipe_own_q [RD_LAT];
  logic [OW-1:0]     pipe_own_d [RD_LAT];

  logic [R_PORT_CNT-1:0] rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    cand = '0;
    for (int p = 0; p < R_PORT_CNT; p++) begin
      cand[p] = rreq_i[p] &&
        (rid_i[p*BANK_CNT_LG2 +: BANK_CNT_LG2] == BANK_ID_L);
      addr_a[p] = raddr_i[p*DEPTH_LG2 +: DEPTH_LG2];
    end
  end

  vpu_rr_arbiter #(
    .N(R_PORT_CNT)
  ) u_arb (
    .req_i(cand),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx),
    .vld_o(gnt_vld)
  );

  // SRAM side is driven straight from the owner's live slice
  assign beat       = (state_q == BURST) && !reb_i[owner_q];
  assign last_beat  = beat && rlast_i[owner_q];
  assign pipe_empty = ~|pipe_vld_q;

  assign sram_csb_o  = !beat;
  assign sram_addr_o = beat ? addr_a[owner_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      rack_q  <= '0;
    end else begin
      rack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            owner_q <= gnt_idx;
            rack_q  <= gnt;
            state_q <= GRANT;
          end
        end
        GRANT: state_q <= BURST;
        BURST: begin
          if (last_beat) state_q <= DRAIN;
        end
        DRAIN: begin
          if (pipe_empty) begin
            ptr_q <= (owner_q == OW'(R_PORT_CNT-1))
                     ? '0 : owner_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag each access with its owner so the return lands on one port
  always_comb begin
    pipe_vld_d    = '0;
    pipe_vld_d[0] = beat;
    for (int i = 0; i < RD_LAT; i++) pipe_own_d[i] = '0;
    pipe_own_d[0] = owner_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_own_d[i] = pipe_own_q[i-1];
    end
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (pipe_vld_q[RD_LAT-1]) begin
      rvalid_d[pipe_own_q[RD_LAT-1]] = 1'b1;
      rdata_d = sram_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_own_q[i] <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      for (int i = 0; i < RD_LAT; i++) pipe_own_q[i] <= pipe_own_d[i];
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rack_o   = rack_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = {R_PORT_CNT{rdata_q}};

endmodule
